clk_div_sched: RTL

- Run-time controller for the integer clock divider: sequences start/stop and schedules divide-ratio changes so clk_out never glitches or emits a short period.
- Sits between the configuration master (request/acknowledge handshake) and logic clocked or strobed by the divided clock.
- Generalises the fixed divide-by-3 to a programmable ratio N in 2..2^W-1, with changes applied only at period boundaries.

---
 rtl/clk_div_sched_if.sv | 21 ++
 rtl/clk_div_sched.sv | 139 +++++++++++++
 2 files changed

// File: rtl/clk_div_sched_if.sv
// Configuration handshake between the ratio master and clk_div_sched.
interface clk_div_sched_if #(
  parameter int W = 4
);
  logic         div_req;
  logic [W-1:0] div_val;
  logic         div_ack;
  logic         div_err;
  logic         busy;
  logic [W-1:0] cur_div;

  modport master (
    output div_req, div_val,
    input  div_ack, div_err, busy, cur_div
  );

  modport slave (
    input  div_req, div_val,
    output div_ack, div_err, busy, cur_div
  );
endinterface

// File: rtl/clk_div_sched.sv
// Programmable integer clock divider with glitch-free start/stop and ratio changes at period boundaries.
// Optional CLK_DIV_SCHED_DUTY50_EN adds a negedge flop giving 50% duty for odd ratios.
module clk_div_sched #(
  parameter int W           = 4,
  parameter int DEFAULT_DIV = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  clk_div_sched_if.slave  cfg,
  output logic            clk_out,
  output logic            tick
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cur_q, cur_d;
  logic [W-1:0] pend_q, pend_d;
  logic         ack_q, ack_d;
  logic         err_q, err_d;
  logic         out_q, out_d;
  logic         tick_q, tick_d;
  logic         run_d;
  logic         sample, req_ok, req_bad, wrap;

  // Requests are ignored while busy or while an ack/err pulse is still out.
  assign sample  = cfg.div_req && (state_q != PEND) && !ack_q && !err_q;
  assign req_bad = sample && (cfg.div_val < W'(2));
  assign req_ok  = sample && (cfg.div_val >= W'(2));
  assign wrap    = (cnt_q == cur_q - W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    err_d   = req_bad;
    run_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_ok) begin
          cur_d = cfg.div_val;
          ack_d = 1'b1;
        end
        if (en) begin
          state_d = RUN;
          run_d   = 1'b1;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_d = '0;
          run_d = en;
          if (!en) state_d = IDLE;
          // Stopping at this wrap: nothing follows, so apply the ratio as IDLE would.
          if (req_ok) begin
            if (!en) begin
              cur_d = cfg.div_val;
              ack_d = 1'b1;
            end else begin
              pend_d  = cfg.div_val;
              state_d = PEND;
            end
          end
        end else begin
          cnt_d = cnt_q + W'(1);
          run_d = 1'b1;
          if (req_ok) begin
            pend_d  = cfg.div_val;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (wrap) begin
          cnt_d   = '0;
          cur_d   = pend_q;
          ack_d   = 1'b1;
          run_d   = en;
          state_d = en ? RUN : IDLE;
        end else begin
          cnt_d = cnt_q + W'(1);
          run_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // At a wrap cnt_d is 0, which is below N/2 for any N >= 2, so the old ratio suffices here.
    out_d  = run_d && (cnt_d < (cur_q >> 1));
    tick_d = run_d && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= W'(DEFAULT_DIV);
      pend_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
    end
  end

`ifdef CLK_DIV_SCHED_DUTY50_EN
  logic neg_q;

  // Half-cycle extension of the high phase, only for odd ratios.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) neg_q <= 1'b0;
    else        neg_q <= out_q & cur_q[0];
  end

  assign clk_out = out_q | neg_q;
`else
  assign clk_out = out_q;
`endif

  assign tick        = tick_q;
  assign cfg.div_ack = ack_q;
  assign cfg.div_err = err_q;
  assign cfg.busy    = (state_q == PEND);
  assign cfg.cur_div = cur_q;

endmodule
